keyword_uart_tx: RTL and testbench

Serial transmitter for recognised keywords: watches the debounced keyword ID stream and, on every change to a new non-zero keyword, queues the ID and sends it as one ASCII hex character over an 8N1 UART line to a host terminal. It sits downstream of the keyword debouncer and is the design's only path for reporting recognitions off-chip. A small FIFO absorbs bursts while a frame is in flight.

---
 rtl/keyword_uart_tx.sv | 176 +++++++++++++++++
 tb/tb_keyword_uart_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/keyword_uart_tx.sv
// rtl/keyword_uart_tx.sv - keyword change detector, event FIFO and 8N1 hex-character UART transmitter
module keyword_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] keyword_in,
  input  logic       overflow_clr,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       overflow
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL      = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          txd_q, txd_d;
  logic [3:0]    last_kw_q, last_kw_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [3:0]    mem_d [FIFO_DEPTH];

  logic push, pop, full, push_ok, drop;

  // Hex digit to ASCII: '0'..'9' then 'A'..'F'
  function automatic logic [7:0] encode(input logic [3:0] id);
    return (id < 4'd10) ? (8'h30 + {4'h0, id}) : (8'h37 + {4'h0, id});
  endfunction

  // A new event is any change to a non-zero keyword; popping only from IDLE
  assign push    = (keyword_in != last_kw_q) && (keyword_in != 4'd0);
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign full    = (count_q == FULL);
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  // Event FIFO, last-keyword tracking and sticky overflow (set beats clear)
  always_comb begin
    last_kw_d  = keyword_in;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = keyword_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  // TX frame sequencer: start bit, 8 data bits LSB first, stop bit
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          shreg_d = encode(mem_q[rd_ptr_q]);
          state_d = S_START;
          baud_d  = '0;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          state_d = S_IDLE;
          baud_d  = '0;
          txd_d   = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  // State registers; reset snaps the line high even mid-frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      txd_q      <= 1'b1;
      last_kw_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
      last_kw_q  <= last_kw_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign uart_txd = txd_q;
  assign overflow = overflow_q;
  assign tx_busy  = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_keyword_uart_tx.sv
// tb/tb_keyword_uart_tx.sv - self-checking bench for keyword_uart_tx against a frame-timing reference model
module tb_keyword_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [7:0] CH_0 = "0";
  localparam logic [7:0] CH_A = "A";

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] keyword_in = 4'd0;
  logic       overflow_clr = 1'b0;
  logic       uart_txd;
  logic       tx_busy;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  keyword_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .keyword_in   (keyword_in),
    .overflow_clr (overflow_clr),
    .uart_txd     (uart_txd),
    .tx_busy      (tx_busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of pending IDs plus the start edge and byte of the current frame
  int         m_edge = 0;
  bit         m_fvalid = 1'b0;
  int         m_fstart = 0;
  logic [7:0] m_fbyte = 8'h00;
  logic [3:0] m_q[$];
  logic [3:0] m_last = 4'd0;
  bit         m_ovf = 1'b0;

  function automatic logic [7:0] hexchar(input logic [3:0] id);
    if (id < 10) return CH_0 + 8'(id);
    return CH_A + 8'(id) - 8'd10;
  endfunction

  function automatic bit m_idle_before(input int e);
    return !m_fvalid || (e > m_fstart + FRAME);
  endfunction

  function automatic logic exp_txd();
    int k;
    if (m_fvalid && m_edge < m_fstart + FRAME) begin
      k = (m_edge - m_fstart) / CPB;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_fbyte[k-1];
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    return (m_fvalid && m_edge < m_fstart + FRAME) || (m_q.size() != 0);
  endfunction

  task automatic model_reset();
    m_fvalid = 1'b0;
    m_q.delete();
    m_last = 4'd0;
    m_ovf  = 1'b0;
  endtask

  // Advance the model by one active edge
  always @(posedge clk) begin
    if (rst_n) begin
      bit pop, push;
      m_edge++;
      pop  = m_idle_before(m_edge) && (m_q.size() != 0);
      push = (keyword_in != m_last) && (keyword_in != 4'd0);
      if (overflow_clr) m_ovf = 1'b0;
      if (push && m_q.size() == DEPTH && !pop) m_ovf = 1'b1;
      if (pop) begin
        m_fbyte  = hexchar(m_q.pop_front());
        m_fstart = m_edge;
        m_fvalid = 1'b1;
      end
      if (push && m_q.size() < DEPTH) m_q.push_back(keyword_in);
      m_last = keyword_in;
    end
  end

  // Compare every output every cycle, away from the active edge
  always @(negedge clk) begin
    check("txd", uart_txd, exp_txd());
    check("busy", tx_busy, exp_busy());
    check("ovf", overflow, m_ovf);
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_txd", uart_txd, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    cycles(hold);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset
    cycles(3);
    check("por_txd", uart_txd, 1'b1);
    check("por_busy", tx_busy, 1'b0);
    #2;
    rst_n = 1'b1;

    // Zero suppression, including a reset with keyword_in at 0
    cycles(20);
    do_reset(3);
    cycles(20);
    check("zero_busy", tx_busy, 1'b0);
    check("zero_txd", uart_txd, 1'b1);

    // Single event: push edge raises busy, next edge starts the frame
    @(negedge clk);
    keyword_in = 4'd5;
    @(negedge clk);
    check("single_push_busy", tx_busy, 1'b1);
    check("single_push_txd", uart_txd, 1'b1);
    @(negedge clk);
    check("single_start_txd", uart_txd, 1'b0);
    cycles(FRAME + 5);
    check("single_done_busy", tx_busy, 1'b0);

    // Hex letter and repeats after silence; a long hold gives one frame
    keyword_in = 4'd0;  cycles(10);
    keyword_in = 4'd12; cycles(50);
    keyword_in = 4'd0;  cycles(10);
    keyword_in = 4'd12; cycles(200);
    check("hold_busy", tx_busy, 1'b0);

    // Burst of six: five fit, the sixth is dropped
    keyword_in = 4'd0; cycles(5);
    for (int k = 1; k <= 6; k++) begin
      keyword_in = 4'(k);
      @(negedge clk);
    end
    check("burst_ovf", overflow, 1'b1);
    cycles(5 * (FRAME + 1) + 10);
    check("burst_done_busy", tx_busy, 1'b0);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("burst_clr_ovf", overflow, 1'b0);

    // Full FIFO with a push landing on the pop edge
    keyword_in = 4'd0; cycles(5);
    for (int k = 1; k <= 5; k++) begin
      keyword_in = 4'(k);
      @(negedge clk);
    end
    begin
      int guard = 0;
      while (!(m_idle_before(m_edge + 1) && m_q.size() == DEPTH) && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) check("fullpop_wait", 32'd0, 32'd1);
    end
    keyword_in = 4'd9;
    @(negedge clk);
    check("fullpop_ovf", overflow, 1'b0);
    check("fullpop_start", uart_txd, 1'b0);
    cycles(6 * (FRAME + 1));
    check("fullpop_done", tx_busy, 1'b0);

    // Reset during data bit 3, then a held keyword restarts a full frame
    keyword_in = 4'd0; cycles(5);
    keyword_in = 4'd3;
    cycles(2 + 4 * CPB + 1);
    keyword_in = 4'd7;
    do_reset(3);
    @(negedge clk);
    check("rr_push_txd", uart_txd, 1'b1);
    check("rr_push_busy", tx_busy, 1'b1);
    @(negedge clk);
    check("rr_start_txd", uart_txd, 1'b0);
    cycles(FRAME + 5);

    // Randomised keyword streams with clears and occasional resets
    for (int it = 0; it < 150; it++) begin
      keyword_in = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) overflow_clr = 1'b1;
      @(negedge clk);
      overflow_clr = 1'b0;
      cycles($urandom_range(0, 40));
      if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 4));
    end
    keyword_in = 4'd0;
    cycles(DEPTH * (FRAME + 1) + FRAME + 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
